lane_queue_sensor: RTL

- Vehicle-side counterpart of the intersection controller. Consumes the four 3-bit light codes Ta..Td and per-lane arrival pulses, and produces the 2-bit sensor readings Sa..Sd that feed the controller.
- Models one vehicle queue per lane (A..D): arrivals enqueue, departures drain on green, and each queue length is encoded into the sensor format.
- Used as a closed-loop stimulus model in system simulation and as an on-chip sensor conditioner.

---
 rtl/lane_queue_sensor.sv | 110 +++++++++++
 1 files changed

// File: rtl/lane_queue_sensor.sv
// Per-lane vehicle queue model: arrivals enqueue, green drains one vehicle per DEPART_CYC cycles,
// and each queue length is encoded as a 2-bit sensor reading. `LANE_QUEUE_SENSOR_HYST_EN adds sensor hysteresis.
module lane_queue_sensor #(
    parameter int unsigned QW         = 4,
    parameter int unsigned LOW_TH     = 1,
    parameter int unsigned HIGH_TH    = 4,
    parameter int unsigned DEPART_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] arrive,
    input  logic [2:0] Ta,
    input  logic [2:0] Tb,
    input  logic [2:0] Tc,
    input  logic [2:0] Td,
    output logic [1:0] Sa,
    output logic [1:0] Sb,
    output logic [1:0] Sc,
    output logic [1:0] Sd,
    output logic [3:0] depart,
    output logic [3:0] ovf
);

    localparam int unsigned TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYC - 1);
    localparam logic [QW-1:0] Q_MAX  = '1;
    localparam logic [2:0]    GREEN  = 3'b001;

    logic [2:0] w_light [4];
    logic [1:0] w_sens  [4];

    assign w_light[0] = Ta;
    assign w_light[1] = Tb;
    assign w_light[2] = Tc;
    assign w_light[3] = Td;

    assign Sa = w_sens[0];
    assign Sb = w_sens[1];
    assign Sc = w_sens[2];
    assign Sd = w_sens[3];

    function automatic logic [1:0] f_enc(input logic [QW-1:0] q);
        if (q >= QW'(HIGH_TH))     return 2'b11;
        else if (q >= QW'(LOW_TH)) return 2'b01;
        else                       return 2'b00;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [QW-1:0] r_q;
        logic [TW-1:0] r_t;
        logic          r_dep;
        logic          r_ovf;
        logic [1:0]    r_sens;

        logic          w_green;
        logic          w_dep;
        logic          w_set_ovf;
        logic [QW-1:0] w_q_nxt;
        logic [TW-1:0] w_t_nxt;
        logic [1:0]    w_sens_nxt;

        // Departure timer and queue next-state
        always_comb begin
            w_green   = (w_light[g] == GREEN);
            w_dep     = 1'b0;
            w_set_ovf = 1'b0;
            w_t_nxt   = '0;
            w_q_nxt   = r_q;
            if (w_green && (r_q != '0)) begin
                if (r_t == T_LAST) w_dep   = 1'b1;
                else               w_t_nxt = r_t + TW'(1);
            end
            if (arrive[g] && !w_dep) begin
                if (r_q == Q_MAX) w_set_ovf = 1'b1;
                else              w_q_nxt   = r_q + QW'(1);
            end else if (w_dep && !arrive[g]) begin
                w_q_nxt = r_q - QW'(1);
            end
        end

        // Sensor level follows the registered queue; hysteresis holds 11 until q < HIGH_TH-1
        always_comb begin
            w_sens_nxt = f_enc(r_q);
`ifdef LANE_QUEUE_SENSOR_HYST_EN
            if ((r_sens == 2'b11) && (r_q >= QW'(HIGH_TH - 1))) w_sens_nxt = 2'b11;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q    <= '0;
                r_t    <= '0;
                r_dep  <= 1'b0;
                r_ovf  <= 1'b0;
                r_sens <= 2'b00;
            end else begin
                r_q    <= w_q_nxt;
                r_t    <= w_t_nxt;
                r_dep  <= w_dep;
                r_ovf  <= r_ovf | w_set_ovf;
                r_sens <= w_sens_nxt;
            end
        end

        assign depart[g] = r_dep;
        assign ovf[g]    = r_ovf;
        assign w_sens[g] = r_sens;
    end

endmodule
